// File: rtl/atu_tune_ctrl.sv
// atu_tune_ctrl
//
// Sequencer for the external antenna tuner (V4 ATU). A one-cycle tune request
// becomes a timed START pulse toward the tuner. The block then watches the
// tuner's KEY/status line and requests a carrier for the length of the tune.
// Each attempt ends with a one-cycle done pulse and a result code. Board-level
// inversions on the tuner pins are handled outside this block.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active high
//   tune_start  one-cycle start pulse, honoured only in IDLE
//   tune_abort  level, aborts any active tune
//   atu_ack     tuner busy/KEY, asynchronous to clk
//   atu_req     START drive to the tuner
//   tune_tx     carrier request to the transmit path
//   busy        high whenever the sequencer is not idle
//   done        one-cycle pulse at the end of each attempt
//   result      0 ok, 1 no-ack timeout, 2 tune timeout, 3 aborted
//
// Compile option:
//   ATU_ACK_FILTER_EN  when defined, ack_s only follows the synchronized ack
//                      after it has held a new level for 4 consecutive ms
//                      ticks of a free-running prescaler (3..4 ms latency).
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for tune_start, outputs low
// REQ     | START pulse toward the tuner, REQ_MS long
// WAITACK | carrier on, waiting up to ACK_WAIT_MS for ack
// TUNE    | carrier on while ack is high, up to TUNE_MAX_MS
// FIN     | one cycle, done pulse with result code

module atu_tune_ctrl #(
    parameter int TICK_DIV    = 76800,
    parameter int REQ_MS      = 64,
    parameter int ACK_WAIT_MS = 512,
    parameter int TUNE_MAX_MS = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tune_start,
    input  logic       tune_abort,
    input  logic       atu_ack,
    output logic       atu_req,
    output logic       tune_tx,
    output logic       busy,
    output logic       done,
    output logic [1:0] result
);

    localparam int MAX_AB = (REQ_MS > ACK_WAIT_MS) ? REQ_MS : ACK_WAIT_MS;
    localparam int MAX_MS = (MAX_AB > TUNE_MAX_MS) ? MAX_AB : TUNE_MAX_MS;
    localparam int MSW    = $clog2(MAX_MS + 1);
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]  PRE_TC  = PW'(TICK_DIV - 1);
    localparam logic [MSW-1:0] MS_SAT  = '1;
    localparam logic [MSW-1:0] MS_REQ  = MSW'(REQ_MS);
    localparam logic [MSW-1:0] MS_ACK  = MSW'(ACK_WAIT_MS);
    localparam logic [MSW-1:0] MS_TUNE = MSW'(TUNE_MAX_MS);

    localparam logic [1:0] RES_OK       = 2'd0;
    localparam logic [1:0] RES_NO_ACK   = 2'd1;
    localparam logic [1:0] RES_TUNE_TO  = 2'd2;
    localparam logic [1:0] RES_ABORTED  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAITACK,
        ST_TUNE,
        ST_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic [1:0]     result_q, result_d;
    logic           atu_req_q, atu_req_d;
    logic           tune_tx_q, tune_tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;

    logic           ack_s;
    logic           tick;
    logic [MSW-1:0] ms_inc;
    logic           req_hit;
    logic           ack_hit;
    logic           tune_hit;

    // ---------------------------------------------------------------
    // ack synchronizer (and optional debounce filter)
    // ---------------------------------------------------------------
    always_comb begin
        sync1_d = atu_ack;
        sync2_d = sync1_q;
    end

`ifdef ATU_ACK_FILTER_EN
    logic [PW-1:0] fpresc_q, fpresc_d;
    logic [1:0]    fcnt_q, fcnt_d;
    logic          ack_f_q, ack_f_d;
    logic          ftick;

    // Free-running so the filter delay does not depend on state entries.
    assign ftick = (fpresc_q == PRE_TC);

    always_comb begin
        fpresc_d = ftick ? '0 : fpresc_q + PW'(1);
        fcnt_d   = fcnt_q;
        ack_f_d  = ack_f_q;
        if (sync2_q == ack_f_q) begin
            fcnt_d = '0;
        end else if (ftick) begin
            // The fourth consecutive tick at the new level commits it.
            if (fcnt_q == 2'd3) begin
                ack_f_d = sync2_q;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpresc_q <= '0;
            fcnt_q   <= '0;
            ack_f_q  <= 1'b0;
        end else begin
            fpresc_q <= fpresc_d;
            fcnt_q   <= fcnt_d;
            ack_f_q  <= ack_f_d;
        end
    end

    assign ack_s = ack_f_q;
`else
    assign ack_s = sync2_q;
`endif

    // ---------------------------------------------------------------
    // ms timebase: hit flags fire on the cycle whose tick brings the
    // count to the limit, so each state lasts exactly limit*TICK_DIV.
    // ---------------------------------------------------------------
    assign tick     = (presc_q == PRE_TC);
    assign ms_inc   = (tick && (ms_q != MS_SAT)) ? ms_q + MSW'(1) : ms_q;
    assign req_hit  = tick && (ms_inc == MS_REQ);
    assign ack_hit  = tick && (ms_inc == MS_ACK);
    assign tune_hit = tick && (ms_inc == MS_TUNE);

    // ---------------------------------------------------------------
    // next state / result
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (tune_start && !tune_abort) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (tune_abort) begin
                    state_d  = ST_FIN;
                    result_d = RES_ABORTED;
                end else if (req_hit) begin
                    state_d = ST_WAITACK;
                end
            end
            ST_WAITACK: begin
                if (tune_abort) begin
                    state_d  = ST_FIN;
                    result_d = RES_ABORTED;
                end else if (ack_s) begin
                    state_d = ST_TUNE;
                end else if (ack_hit) begin
                    state_d  = ST_FIN;
                    result_d = RES_NO_ACK;
                end
            end
            ST_TUNE: begin
                // Ack release is checked before the timeout so a tie is ok.
                if (tune_abort) begin
                    state_d  = ST_FIN;
                    result_d = RES_ABORTED;
                end else if (!ack_s) begin
                    state_d  = ST_FIN;
                    result_d = RES_OK;
                end else if (tune_hit) begin
                    state_d  = ST_FIN;
                    result_d = RES_TUNE_TO;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Timebase restarts on every state entry and stays cleared in IDLE.
    always_comb begin
        presc_d = '0;
        ms_d    = '0;
        if ((state_d == state_q) && (state_q != ST_IDLE)) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            ms_d    = ms_inc;
        end
    end

    // Outputs decode the next state so they change on the state edge.
    always_comb begin
        atu_req_d = (state_d == ST_REQ);
        tune_tx_d = (state_d == ST_WAITACK) || (state_d == ST_TUNE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            ms_q      <= '0;
            result_q  <= RES_OK;
            atu_req_q <= 1'b0;
            tune_tx_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
            result_q  <= result_d;
            atu_req_q <= atu_req_d;
            tune_tx_q <= tune_tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign atu_req = atu_req_q;
    assign tune_tx = tune_tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: doc/atu_tune_ctrl.md
# atu_tune_ctrl

Sequencer for the external antenna tuner on the AK4951 companion board (V4 ATU). It converts a one-cycle tune request from the core into a timed START pulse toward the tuner, monitors the tuner's KEY/status line, and asserts a carrier request for the duration of the tune. Each attempt ends with a one-cycle completion pulse and a result code. The block sits between the core's ATU logic and the io_db1_1 / io_link_rx[1] pins, and the board-level inversions remain outside the block.

## Interface
Parameters:
- TICK_DIV, 76800: clock cycles per 1 ms tick (76.8 MHz clock).
- REQ_MS, 64: START pulse width in ms.
- ACK_WAIT_MS, 512: maximum ms from START release until the tuner asserts ack.
- TUNE_MAX_MS, 10000: maximum ms that ack may remain asserted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- tune_start, input, 1: one-cycle pulse that starts a tune. Ignored unless the block is idle.
- tune_abort, input, 1: level input. Aborts any active tune.
- atu_ack, input, 1: tuner busy/KEY, active high. Asynchronous to clk.
- atu_req, output, 1: START drive to the tuner, active high.
- tune_tx, output, 1: requests a carrier from the transmit path.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at the end of each attempt.
- result, output, 2: code for the last attempt. 0 = ok, 1 = no-ack timeout, 2 = tune timeout, 3 = aborted. Holds until the next done pulse.

## Operation
- atu_ack passes through a 2-flop synchronizer. The synchronized signal is ack_s.
- The ms prescaler counts 0..TICK_DIV-1 and emits a tick on the terminal count. The prescaler and the ms counter both clear on every state entry, so state durations are exact multiples of TICK_DIV cycles.
- Width rule: the ms counter is $clog2(max(REQ_MS, ACK_WAIT_MS, TUNE_MAX_MS)+1) bits wide and saturates. It must not wrap.
- States:
  - IDLE: all outputs low except result. tune_start with tune_abort low moves to REQ.
  - REQ: atu_req=1, tune_tx=0. Moves to WAITACK when ms count reaches REQ_MS.
  - WAITACK: atu_req=0, tune_tx=1. ack_s=1 moves to TUNE. Reaching ACK_WAIT_MS moves to FIN with result=1.
  - TUNE: tune_tx=1. ack_s=0 moves to FIN with result=0. Reaching TUNE_MAX_MS moves to FIN with result=2.
  - FIN: lasts one cycle. done=1, busy=1, then returns to IDLE.
- tune_abort in REQ, WAITACK or TUNE moves to FIN with result=3 on the next edge. Abort has priority over every other transition evaluated in the same cycle.
- Simultaneous ack_s fall and TUNE_MAX_MS expiry in TUNE resolves to result=0.
- tune_start is ignored in every state other than IDLE, including FIN. It is not queued.
- Asynchronous reset clears every register, including result. Reset in the middle of a tune drops atu_req and tune_tx immediately and does not emit done.

## Timing
- Reset values: atu_req=0, tune_tx=0, busy=0, done=0, result=0, state=IDLE.
- All outputs are registered.
- tune_start at edge N: atu_req and busy are high from edge N+1. atu_req stays high for exactly REQ_MS*TICK_DIV cycles, then falls on the same edge at which tune_tx rises.
- Input latency to ack_s: 2 cycles of synchronizer, plus the filter delay when the filter is compiled in.
- ack_s transition to state change: 1 cycle.
- done is high for exactly one cycle. result becomes valid on the same edge as done rises.
- busy falls on the edge after done.

## Configuration
- ATU_ACK_FILTER_EN defined: ack_s changes only after the synchronized input has held a new level for 4 consecutive ms ticks. The tick source for this filter is a free-running prescaler, separate from the state prescaler, so added latency is 3 to 4 ms. The filter rejects contact bounce and glitches.
- ATU_ACK_FILTER_EN undefined: ack_s is the synchronizer output directly. There is no filter logic.

## Test plan
Run all scenarios with TICK_DIV=10, REQ_MS=4, ACK_WAIT_MS=8, TUNE_MAX_MS=20, filter undefined unless stated.
- Nominal: tune_start pulse; raise atu_ack 3 ms after atu_req falls and hold it 6 ms. Required: atu_req high for exactly 40 cycles; tune_tx high until 3 cycles after atu_ack falls; done pulse with result=0.
- No ack: tune_start with atu_ack held low. Required: tune_tx high for exactly 80 cycles; done with result=1.
- Stuck tuner: raise atu_ack and never release it. Required: TUNE lasts 200 cycles; done with result=2.
- Abort and ignore: assert tune_abort during TUNE. Required: on the next edge the block enters FIN, result=3, tune_tx=0. A second tune_start during TUNE has no effect.
- Reset mid-REQ: assert rst asynchronously. Required: atu_req=0 and busy=0 immediately; no done pulse; result=0.
- ATU_ACK_FILTER_EN defined: apply a 2 ms ack glitch during WAITACK. Required: no transition to TUNE; attempt ends with result=1.
